// File: rtl/spi_bus_master.sv
// SPI mode-0 slave that turns framed commands into parallel bus read/write cycles.
// Frame: command byte, 16-bit address, then 16-bit data words until slave select rises.
module spi_bus_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int BUS_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  spi_sck,
   input  logic                  _spi_ss,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  _bus_en,
   output logic                  _bus_rd,
   output logic                  _bus_wr,
   output logic [1:0]            _bus_be,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_data_out,
   input  logic [DATA_WIDTH-1:0] bus_data_in
);

   localparam logic [1:0] S_CMD  = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic       B_IDLE   = 1'b0;
   localparam logic       B_ACTIVE = 1'b1;
   localparam int         CW = (BUS_CYCLES > 1) ? $clog2(BUS_CYCLES) : 1;
   localparam logic [CW-1:0] BCNT_LAST = CW'(BUS_CYCLES - 1);

   logic [1:0] sck_s, ss_s, mosi_s;
   logic       sck_d, ss_d;
   logic [1:0] settle;
   logic       seen_high;

   logic [1:0]            fstate;
   logic [3:0]            bit_cnt;
   logic [DATA_WIDTH-1:0] shift_in;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] tx;
   logic                  cmd_wr;
   logic [1:0]            cmd_be;
   logic                  in_frame;
   logic                  req;

   logic          bstate;
   logic [CW-1:0] bcnt;
   logic          cyc_rd;
   logic [1:0]    be_reg;

   logic ss_high, ss_fall, sck_rise, sck_fall, mosi;
   logic [DATA_WIDTH-1:0] shifted;

   // Synchronizers; a frame may only open once slave select has been seen high after reset.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         sck_s     <= 2'b00;
         ss_s      <= 2'b11;
         mosi_s    <= 2'b00;
         sck_d     <= 1'b0;
         ss_d      <= 1'b1;
         settle    <= 2'd0;
         seen_high <= 1'b0;
      end else begin
         sck_s  <= {sck_s[0], spi_sck};
         ss_s   <= {ss_s[0], _spi_ss};
         mosi_s <= {mosi_s[0], spi_mosi};
         sck_d  <= sck_s[1];
         ss_d   <= ss_s[1];
         if (settle != 2'd2)
            settle <= settle + 2'd1;
         if (settle == 2'd2 && ss_s[1])
            seen_high <= 1'b1;
      end
   end

   assign ss_high  = ss_s[1];
   assign mosi     = mosi_s[1];
   assign ss_fall  = seen_high & ss_d & ~ss_s[1];
   assign sck_rise = in_frame & sck_s[1] & ~sck_d;
   assign sck_fall = in_frame & ~sck_s[1] & sck_d;
   assign shifted  = {shift_in[DATA_WIDTH-2:0], mosi};

   // Frame decoder and bus cycle engine share one block since both update bus_addr and tx.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         fstate       <= S_CMD;
         bit_cnt      <= 4'd0;
         shift_in     <= '0;
         wdata        <= '0;
         tx           <= '0;
         cmd_wr       <= 1'b0;
         cmd_be       <= 2'b00;
         in_frame     <= 1'b0;
         req          <= 1'b0;
         bstate       <= B_IDLE;
         bcnt         <= '0;
         cyc_rd       <= 1'b0;
         be_reg       <= 2'b11;
         bus_addr     <= '0;
         bus_data_out <= '0;
      end else begin
         req <= 1'b0;
         if (ss_high)
            in_frame <= 1'b0;
         else if (ss_fall)
            in_frame <= 1'b1;

         if (ss_high || ss_fall) begin
            fstate  <= S_CMD;
            bit_cnt <= 4'd0;
         end else if (sck_rise) begin
            shift_in <= shifted;
            bit_cnt  <= bit_cnt + 4'd1;
            case (fstate)
               S_CMD: begin
                  if (bit_cnt == 4'd7) begin
                     cmd_wr  <= shift_in[6];
                     cmd_be  <= {shift_in[0], mosi};
                     fstate  <= S_ADDR;
                     bit_cnt <= 4'd0;
                  end
               end
               S_ADDR: begin
                  if (bit_cnt == 4'd15) begin
                     bus_addr <= ADDR_WIDTH'(shifted);
                     fstate   <= S_DATA;
                     bit_cnt  <= 4'd0;
                     req      <= ~cmd_wr;
                  end
               end
               S_DATA: begin
                  if (bit_cnt == 4'd15) begin
                     wdata   <= shifted;
                     bit_cnt <= 4'd0;
                     req     <= 1'b1;
                  end
               end
               default: fstate <= S_CMD;
            endcase
         end else if (sck_fall && fstate == S_DATA && !cmd_wr && bit_cnt != 4'd0) begin
            tx <= {tx[DATA_WIDTH-2:0], 1'b0};
         end

         // Requests arriving after slave select rose are dropped; a running cycle always finishes.
         case (bstate)
            B_IDLE: begin
               if (req && !ss_high) begin
                  bstate <= B_ACTIVE;
                  bcnt   <= '0;
                  cyc_rd <= ~cmd_wr;
                  be_reg <= cmd_wr ? ~cmd_be : 2'b00;
                  if (cmd_wr)
                     bus_data_out <= wdata;
               end
            end
            B_ACTIVE: begin
               if (bcnt == BCNT_LAST) begin
                  bstate   <= B_IDLE;
                  bus_addr <= bus_addr + 1'b1;
                  if (cyc_rd)
                     tx <= bus_data_in;
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            default: bstate <= B_IDLE;
         endcase
      end
   end

   assign _bus_en  = (bstate != B_ACTIVE);
   assign _bus_rd  = ~((bstate == B_ACTIVE) & cyc_rd);
   assign _bus_wr  = ~((bstate == B_ACTIVE) & ~cyc_rd);
   assign _bus_be  = (bstate == B_ACTIVE) ? be_reg : 2'b11;
   assign spi_miso = in_frame & (fstate == S_DATA) & ~cmd_wr & tx[DATA_WIDTH-1];

endmodule

// File: doc/spi_bus_master.md
SPI_BUS_MASTER -- requirements
Module: spi_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bus data width (fixed 16 for this frame format).
REQ-003 SHALL have parameter BUS_CYCLES, default 2, clk cycles each bus strobe is held low.
REQ-004 SHALL have port clk  input  1  system clock, single clock domain.
REQ-005 SHALL have port _reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports spi_sck, _spi_ss, spi_mosi  input  1 each  SPI mode-0 slave inputs; _spi_ss active low.
REQ-007 SHALL have port spi_miso  output  1  serial read data.
REQ-008 SHALL have ports _bus_en, _bus_rd, _bus_wr  output  1 each  bus strobes, active low.
REQ-009 SHALL have port _bus_be  output  2  byte enables, active low.
REQ-010 SHALL have port bus_addr  output  ADDR_WIDTH  bus address.
REQ-011 SHALL have ports bus_data_out  output  16  write data; bus_data_in  input  16  read data.

Function
REQ-012 SHALL pass spi_sck, _spi_ss, spi_mosi through 2-FF synchronizers; all SPI edge detection uses synchronized values.
REQ-013 SHALL sample MOSI on synchronized SCK rising edge, MSB first; shift MISO on falling edge.
REQ-014 SHALL frame as: command byte, address high byte, address low byte, then 16-bit data words MSB first, repeating until _spi_ss rises.
REQ-015 SHALL decode command: bit7 1=write, 0=read; bits[1:0] active-high write byte enables; bits[6:2] ignored.
REQ-016 SHALL use frame states S_CMD -> S_ADDR (16 bits) -> S_DATA; falling _spi_ss returns to S_CMD with bit counter 0.
REQ-017 SHALL run bus FSM B_IDLE -> B_ACTIVE (BUS_CYCLES clks) -> B_IDLE; in B_ACTIVE _bus_en and the selected strobe are 0; never both _bus_rd and _bus_wr low.
REQ-018 Write: SHALL enter B_ACTIVE 1 clk after the 16th data bit of a word is sampled, with bus_data_out = word, _bus_be = ~cmd[1:0]; cmd[1:0]=00 SHALL still run the cycle with _bus_be=11.
REQ-019 Read: SHALL start a read cycle (_bus_be=00) 1 clk after the 16th address bit, and again 1 clk after the 16th bit of each data word (prefetch).
REQ-020 SHALL latch bus_data_in on the last clk of a read B_ACTIVE into the tx register; spi_miso = tx[15].
REQ-021 SHALL shift tx on falling SCK edges only when the in-word bit counter is 1..15 (no shift on the falling edge following a word load).
REQ-022 SHALL increment bus_addr by 1 (wrap at 2^ADDR_WIDTH) at end of every bus cycle; address FFFF wraps to 0000.
REQ-023 SHALL drive spi_miso=0 during S_CMD/S_ADDR, write frames, and while _spi_ss high.
REQ-024 Supported SCK: each SCK half-period >= BUS_CYCLES+4 clk; faster SCK is unsupported.
REQ-025 _spi_ss rising mid-frame SHALL discard partial bytes/words; a bus cycle already in B_ACTIVE SHALL complete its full BUS_CYCLES, none newly started.
REQ-026 Outside B_ACTIVE, _bus_en/_bus_rd/_bus_wr SHALL be 1 and _bus_be 11.

Reset
REQ-027 On _reset low, immediately: _bus_en=_bus_rd=_bus_wr=1, _bus_be=11, bus_addr=0, bus_data_out=0, spi_miso=0, tx=0, states S_CMD/B_IDLE, counters 0, synchronizers to idle (sck 0, ss 1).
REQ-028 Reset asserted mid bus cycle SHALL abort it with strobes high in the same instant.
REQ-029 After _reset rises, SHALL ignore SPI until _spi_ss observed high then low.

Verification
REQ-030 Write: frame 0x83,0x12,0x34,0xBE,0xEF -> one cycle addr 0x1234, data 0xBEEF, _bus_be=00, _bus_wr low exactly 2 clk.
REQ-031 Burst read: 0x00,0x40,0x00, bus returns 0xA5A5 @0x4000, 0x1234 @0x4001 -> MISO 0xA5A5 then 0x1234; three read cycles (0x4000-0x4002).
REQ-032 Byte write: cmd 0x81 -> _bus_be=10 during write; cmd 0x80 -> cycle with _bus_be=11.
REQ-033 Wrap: write burst at 0xFFFF, two words -> cycles at 0xFFFF then 0x0000.
REQ-034 Abort: _spi_ss high after 8 data bits -> no bus cycle; next frame decodes cleanly from command byte.
REQ-035 Reset during B_ACTIVE -> strobes high asynchronously, bus_addr=0, miso=0.
